// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, instruction type enum and decoded payload shared by the decode stage (DECODE_STAGE_ILLEGAL_EN adds the illegal flag)
package decode_pkg;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  typedef enum logic [2:0] {T_R, T_I, T_S, T_B, T_U, T_J, T_N} inst_type_t;
  typedef struct packed {
    logic [63:0] pc;
    inst_type_t  typ;
    logic        wen;
    logic        en_imm;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
`ifdef DECODE_STAGE_ILLEGAL_EN
    logic        illegal;
`endif
  } payload_t;
endpackage

// File: rtl/decode_core.sv
// decode_core: combinational RV instruction decode into the payload struct (DECODE_STAGE_ILLEGAL_EN adds illegal detection)
module decode_core
  import decode_pkg::*;
#(
  parameter int XLEN = 64
`ifdef DECODE_STAGE_ILLEGAL_EN
  , parameter int REG_AW = 5
`endif
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output payload_t        p
);
  logic [6:0] op;
  logic [51:0] sx;
  inst_type_t t;
  assign op = inst[6:0];
  assign sx = {52{inst[31]}};
  assign t = (op == OPC_OP || op == OPC_OP_32) ? T_R :
             (op == OPC_OP_IMM || op == OPC_OP_IMM_32 || op == OPC_LOAD || op == OPC_JALR || op == OPC_SYSTEM) ? T_I :
             (op == OPC_STORE) ? T_S :
             (op == OPC_BRANCH) ? T_B :
             (op == OPC_LUI || op == OPC_AUIPC) ? T_U :
             (op == OPC_JAL) ? T_J : T_N;
  // Assemble payload: immediates are sign-extended from inst[31] to 64 bits, truncated later to XLEN
  always_comb begin
    p = '0;
    p.pc = 64'(pc);
    p.typ = t;
    p.rs1 = inst[19:15];
    p.rs2 = inst[24:20];
    p.rd = inst[11:7];
    p.en_imm = t != T_R && t != T_N;
    p.imm = t == T_I ? {sx, inst[31:20]} :
            t == T_S ? {sx, inst[31:25], inst[11:7]} :
            t == T_B ? {sx[50:0], inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
            t == T_U ? {sx[31:0], inst[31:12], 12'h000} :
            t == T_J ? {sx[42:0], inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} : 64'h0;
    p.wen = (t == T_R || t == T_I || t == T_U || t == T_J) && inst[11:7] != 5'd0;
`ifdef DECODE_STAGE_ILLEGAL_EN
    p.illegal = t == T_N || inst[1:0] != 2'b11 ||
                (REG_AW == 4 && ((p.wen && inst[11]) ||
                                 ((t == T_R || t == T_I || t == T_S || t == T_B) && inst[19]) ||
                                 ((t == T_R || t == T_S || t == T_B) && inst[24])));
    p.wen = p.wen && !p.illegal;
`endif
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: decode pipeline stage with output register and one-entry skid buffer (DECODE_STAGE_ILLEGAL_EN adds out_illegal)
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [2:0]        out_type,
  output logic              out_wen,
  output logic              out_en_imm,
  output logic [XLEN-1:0]   out_imm,
  output logic [REG_AW-1:0] out_raddr1,
  output logic [REG_AW-1:0] out_raddr2,
  output logic [REG_AW-1:0] out_waddr
`ifdef DECODE_STAGE_ILLEGAL_EN
  , output logic            out_illegal
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, nxt;
  payload_t d, out_q, skid_q;
  logic acc, drn;
  decode_core #(
    .XLEN(XLEN)
`ifdef DECODE_STAGE_ILLEGAL_EN
    , .REG_AW(REG_AW)
`endif
  ) u_core (.inst(in_inst), .pc(in_pc), .p(d));
  assign acc = in_valid && in_ready;
  assign drn = out_valid && out_ready;
  assign out_valid = state != EMPTY;
  assign nxt = flush ? EMPTY :
               state == EMPTY ? (acc ? ONE : EMPTY) :
               state == ONE ? ((acc && !drn) ? TWO : (!acc && drn) ? EMPTY : ONE) :
               (drn ? ONE : TWO);
  // State, registered ready and payload; the skid entry always drains into the output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      in_ready <= 1'b0;
      out_q <= '0;
      skid_q <= '0;
    end else begin
      state <= nxt;
      in_ready <= nxt != TWO;
      if (!flush && (state == TWO ? drn : acc && (state == EMPTY || drn))) out_q <= state == TWO ? skid_q : d;
      if (!flush && state == ONE && acc && !drn) skid_q <= d;
    end
  end
  assign out_pc = out_q.pc[XLEN-1:0];
  assign out_type = out_q.typ;
  assign out_wen = out_q.wen;
  assign out_en_imm = out_q.en_imm;
  assign out_imm = out_q.imm[XLEN-1:0];
  assign out_raddr1 = out_q.rs1[REG_AW-1:0];
  assign out_raddr2 = out_q.rs2[REG_AW-1:0];
  assign out_waddr = out_q.rd[REG_AW-1:0];
`ifdef DECODE_STAGE_ILLEGAL_EN
  assign out_illegal = out_q.illegal;
`endif
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode, skid backpressure, flush and reset
module tb_decode_stage;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;
  logic in_ready, out_valid, out_wen, out_en_imm;
  logic [63:0] out_pc, out_imm;
  logic [2:0] out_type;
  logic [4:0] out_raddr1, out_raddr2, out_waddr;
`ifdef DECODE_STAGE_ILLEGAL_EN
  logic out_illegal;
`endif
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_type(out_type),
    .out_wen(out_wen), .out_en_imm(out_en_imm), .out_imm(out_imm), .out_raddr1(out_raddr1),
    .out_raddr2(out_raddr2), .out_waddr(out_waddr)
`ifdef DECODE_STAGE_ILLEGAL_EN
    , .out_illegal(out_illegal)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] i, input logic [63:0] pc);
    in_valid = v;
    in_inst = i;
    in_pc = pc;
  endtask
  initial begin
    tick;
    tick;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_wen", out_wen, 0);
    rst = 1'b1;
    tick;
    chk("ready_rise", in_ready, 1);
    chk("idle_valid", out_valid, 0);
    drive(1, 32'hFFF30293, 64'h1000);
    tick;
    chk("addi_valid", out_valid, 1);
    chk("addi_type", out_type, 1);
    chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_waddr", out_waddr, 5);
    chk("addi_raddr1", out_raddr1, 6);
    chk("addi_wen", out_wen, 1);
    chk("addi_en_imm", out_en_imm, 1);
    chk("addi_pc", out_pc, 64'h1000);
    drive(1, 32'h800000B7, 64'h1004);
    tick;
    chk("lui_type", out_type, 4);
    chk("lui_imm", out_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui_wen", out_wen, 1);
    chk("lui_waddr", out_waddr, 1);
    chk("lui_pc", out_pc, 64'h1004);
    drive(0, 0, 0);
    tick;
    chk("drain_empty", out_valid, 0);
    out_ready = 1'b0;
    drive(1, 32'h00100093, 64'h2000);
    tick;
    chk("bp1_ready", in_ready, 1);
    chk("bp1_pc", out_pc, 64'h2000);
    drive(1, 32'h002081B3, 64'h2004);
    tick;
    chk("bp2_ready", in_ready, 0);
    chk("bp2_valid", out_valid, 1);
    chk("bp2_pc", out_pc, 64'h2000);
    drive(1, 32'h0020A423, 64'h2008);
    tick;
    chk("bp3_ready", in_ready, 0);
    chk("bp3_pc", out_pc, 64'h2000);
    chk("bp3_type", out_type, 1);
    chk("bp3_imm", out_imm, 1);
    out_ready = 1'b1;
    tick;
    chk("rel1_pc", out_pc, 64'h2004);
    chk("rel1_type", out_type, 0);
    chk("rel1_imm", out_imm, 0);
    chk("rel1_waddr", out_waddr, 3);
    chk("rel1_ready", in_ready, 1);
    tick;
    chk("rel2_pc", out_pc, 64'h2008);
    chk("rel2_type", out_type, 2);
    chk("rel2_imm", out_imm, 8);
    chk("rel2_raddr2", out_raddr2, 2);
    chk("rel2_wen", out_wen, 0);
    drive(0, 0, 0);
    tick;
    chk("rel3_empty", out_valid, 0);
    out_ready = 1'b0;
    drive(1, 32'hFE208EE3, 64'h3000);
    tick;
    chk("beq_type", out_type, 3);
    chk("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_wen", out_wen, 0);
    drive(1, 32'h008000EF, 64'h3004);
    tick;
    chk("fl_two_ready", in_ready, 0);
    drive(1, 32'h00100093, 64'h3008);
    flush = 1'b1;
    tick;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    drive(1, 32'h00100093, 64'h300C);
    tick;
    chk("fl_drop_valid", out_valid, 0);
    flush = 1'b0;
    drive(0, 0, 0);
    out_ready = 1'b1;
    tick;
    chk("fl_after_valid", out_valid, 0);
    drive(1, 32'h008000EF, 64'h4000);
    tick;
    chk("jal_pc", out_pc, 64'h4000);
    chk("jal_type", out_type, 5);
    chk("jal_imm", out_imm, 8);
    chk("jal_wen", out_wen, 1);
    drive(1, 32'h00208033, 64'h4004);
    tick;
    chk("x0_type", out_type, 0);
    chk("x0_wen", out_wen, 0);
    chk("x0_raddr1", out_raddr1, 1);
    chk("x0_raddr2", out_raddr2, 2);
    drive(1, 32'h00000000, 64'h4008);
    tick;
    chk("n_type", out_type, 6);
    chk("n_wen", out_wen, 0);
    chk("n_en_imm", out_en_imm, 0);
    chk("n_imm", out_imm, 0);
`ifdef DECODE_STAGE_ILLEGAL_EN
    chk("n_illegal", out_illegal, 1);
`endif
    drive(0, 0, 0);
    tick;
    chk("n_drained", out_valid, 0);
    out_ready = 1'b0;
    drive(1, 32'h00100093, 64'h5000);
    tick;
    drive(1, 32'h002081B3, 64'h5004);
    tick;
    drive(0, 0, 0);
    rst = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_ready", in_ready, 0);
    chk("mrst_pc", out_pc, 0);
    tick;
    rst = 1'b1;
    tick;
    chk("mrst_ready_up", in_ready, 1);
    out_ready = 1'b1;
    tick;
    chk("mrst_no_ghost", out_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, the datapath and immediate width (32 or 64).
REQ-002 The block SHALL have parameter REG_AW, default 5, the register address width (4 for RV-E, 5 for RV-I).
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports in_valid input 1, in_ready output 1, in_inst input 32, in_pc input XLEN as the upstream fetch handshake.
REQ-006 The block SHALL have port flush  input  1  which discards all held instructions.
REQ-007 The block SHALL have ports out_valid output 1 and out_ready input 1 as the downstream handshake.
REQ-008 The block SHALL have payload outputs out_pc XLEN, out_type 3, out_wen 1, out_en_imm 1, out_imm XLEN, out_raddr1 REG_AW, out_raddr2 REG_AW and out_waddr REG_AW.

Function
REQ-009 The block SHALL transfer an input when in_valid&in_ready, and an output when out_valid&out_ready.
REQ-010 The block SHALL present decoded payload one cycle after input acceptance (latency 1) from an output register.
REQ-011 The block SHALL hold a 1-entry skid register; states: EMPTY (nothing held), ONE (output register valid), TWO (output and skid valid).
REQ-012 Transitions SHALL be: EMPTY->ONE on accept; ONE->TWO on accept without drain; ONE->EMPTY on drain without accept; TWO->ONE on drain (skid moves to output); ONE stays on simultaneous accept and drain.
REQ-013 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, driven from a register only (no combinational path from out_ready).
REQ-014 Payload and out_valid SHALL remain stable while out_valid&!out_ready.
REQ-015 flush SHALL force EMPTY next cycle, drop any input offered in the same cycle, and override simultaneous accept/drain.
REQ-016 out_type SHALL encode R=0, I=1, S=2, B=3, U=4, J=5, N=6: OP/OP_32->R; OP_IMM/OP_IMM_32/LOAD/JALR/SYSTEM->I; STORE->S; BRANCH->B; LUI/AUIPC->U; JAL->J; other opcodes->N.
REQ-017 out_imm SHALL be the type-selected immediate sign-extended from inst[31] to full XLEN (U: inst[31:12]<<12 sign-extended); 0 for R and N.
REQ-018 out_wen SHALL be 1 for R, I, U, J types and SHALL be 0 when rd==0.
REQ-019 out_en_imm SHALL be 1 for I, S, B, U, J types.
REQ-020 out_raddr1/2 and out_waddr SHALL be rs1/rs2/rd truncated to REG_AW low bits.

Reset
REQ-021 While rst=0 the block SHALL be EMPTY with out_valid=0, in_ready=0, and all payload outputs 0.
REQ-022 in_ready SHALL rise in the first clock edge after rst deasserts; reset mid-transfer SHALL discard held instructions.

Configuration
REQ-023 With DECODE_STAGE_ILLEGAL_EN defined, the block SHALL add output out_illegal (1 bit), set for type N, for inst[1:0]!=2'b11, or for a REG_AW=4 register field >15, and SHALL force out_wen=0 when set; without it the port is absent and type N passes with out_wen=0.

Structure
REQ-024 Package decode_pkg SHALL hold opcode localparams, the 3-bit inst_type enum, and the decoded payload struct.
REQ-025 Combinational decoding SHALL live in sub-module decode_core (inst, pc -> payload struct), instantiated once ahead of the skid logic.

Verification
REQ-026 The bench SHALL reset, then send addi x5,x6,-1 (0xFFF30293) with out_ready=1 -> next cycle out_type=1, out_imm=64'hFFFF_FFFF_FFFF_FFFF, out_waddr=5, out_raddr1=6, out_wen=1.
REQ-027 The bench SHALL send lui x1,0x80000 (0x800000B7) -> out_type=4, out_imm=64'hFFFF_FFFF_8000_0000, out_wen=1.
REQ-028 The bench SHALL hold out_ready=0 and stream 3 instructions -> 2 accepted, in_ready=0 in TWO, payload stable; release -> outputs in order, no loss or duplicate.
REQ-029 The bench SHALL drive flush in TWO while in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed inputs never appear.
REQ-030 The bench SHALL send add x0,x1,x2 (0x00208033) -> out_wen=0; with DECODE_STAGE_ILLEGAL_EN, send 0x00000000 -> out_illegal=1, out_wen=0.
